dft_sequencer: RTL



---
 rtl/dft_pkg.sv | 65 ++++++
 rtl/dft_sequencer_if.sv | 49 ++++
 rtl/dft_cmac.sv | 57 +++++
 rtl/memory_ed2.sv | 27 ++
 rtl/dft_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dft_pkg
// Brief    : Shared types, widths and quarter-wave twiddle lookup for the
//            sequential DFT engine.
// Revision : 1.0 - initial release
// ============================================================================
package dft_pkg;

    localparam int DFT_N = 16;
    localparam int DFT_W = 16;
    localparam int IDX_W = $clog2(DFT_N);
    localparam int ACC_W = DFT_W + DFT_N;
    localparam int TW_W  = 8;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // round(64*cos(2*pi*phase/64)) built from a 17-entry quarter wave
    function automatic logic signed [TW_W-1:0] cos64(input logic [5:0] phase);
        int                      p;
        logic [4:0]              q;
        logic                    neg;
        logic signed [TW_W-1:0]  mag;
        p = int'(phase);
        if (p <= 16) begin
            q   = 5'(p);
            neg = 1'b0;
        end else if (p <= 32) begin
            q   = 5'(32 - p);
            neg = 1'b1;
        end else if (p <= 48) begin
            q   = 5'(p - 32);
            neg = 1'b1;
        end else begin
            q   = 5'(64 - p);
            neg = 1'b0;
        end
        case (q)
            5'd0:    mag = 8'sd64;
            5'd1:    mag = 8'sd64;
            5'd2:    mag = 8'sd63;
            5'd3:    mag = 8'sd61;
            5'd4:    mag = 8'sd59;
            5'd5:    mag = 8'sd56;
            5'd6:    mag = 8'sd53;
            5'd7:    mag = 8'sd49;
            5'd8:    mag = 8'sd45;
            5'd9:    mag = 8'sd41;
            5'd10:   mag = 8'sd36;
            5'd11:   mag = 8'sd30;
            5'd12:   mag = 8'sd24;
            5'd13:   mag = 8'sd19;
            5'd14:   mag = 8'sd12;
            5'd15:   mag = 8'sd6;
            default: mag = 8'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dft_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : dft_sequencer_if
// Brief     : Sample-in / bin-out stream bundle of the DFT sequencer.
//             Optional DFT_INVERSE_EN adds the inverse-select input.
// Revision  : 1.0 - initial release
// ============================================================================
interface dft_sequencer_if
    import dft_pkg::*;
#(
    parameter int N = DFT_N,
    parameter int W = DFT_W
);
    localparam int c_IW = $clog2(N);

    logic                  in_valid;
    logic                  in_ready;
    logic signed [W:0]     in_re;
    logic signed [W:0]     in_im;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W+N-1:0] out_re;
    logic signed [W+N-1:0] out_im;
    logic [c_IW-1:0]       out_idx;
    logic                  out_last;
    logic                  busy;
`ifdef DFT_INVERSE_EN
    logic                  inverse;

    modport master (
        output in_valid, in_re, in_im, out_ready, inverse,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );
    modport slave (
        input  in_valid, in_re, in_im, out_ready, inverse,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );
`else
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dft_cmac.sv
`default_nettype none
// ============================================================================
// Module   : dft_cmac
// Brief    : Complex multiply-accumulate; o_sum is acc + current product, and
//            i_clr restarts the accumulator after consuming that product.
// Revision : 1.0 - initial release
// ============================================================================
module dft_cmac
    import dft_pkg::*;
#(
    parameter int XW = DFT_W + 1,
    parameter int TW = TW_W,
    parameter int AW = ACC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic                 i_neg_s,
    input  logic signed [XW-1:0] i_xr,
    input  logic signed [XW-1:0] i_xi,
    input  logic signed [TW-1:0] i_c,
    input  logic signed [TW-1:0] i_s,
    output logic signed [AW-1:0] o_sum_re,
    output logic signed [AW-1:0] o_sum_im
);
    localparam int c_PW = XW + TW;

    logic signed [TW-1:0]   w_s;
    logic signed [c_PW-1:0] w_p_cr;
    logic signed [c_PW-1:0] w_p_si;
    logic signed [c_PW-1:0] w_p_ci;
    logic signed [c_PW-1:0] w_p_sr;
    logic signed [AW-1:0]   r_acc_re;
    logic signed [AW-1:0]   r_acc_im;

    assign w_s    = i_neg_s ? -i_s : i_s;
    assign w_p_cr = c_PW'(i_c) * c_PW'(i_xr);
    assign w_p_si = c_PW'(w_s) * c_PW'(i_xi);
    assign w_p_ci = c_PW'(i_c) * c_PW'(i_xi);
    assign w_p_sr = c_PW'(w_s) * c_PW'(i_xr);

    assign o_sum_re = r_acc_re + AW'(w_p_cr) - AW'(w_p_si);
    assign o_sum_im = r_acc_im + AW'(w_p_ci) + AW'(w_p_sr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (i_en) begin
            r_acc_re <= i_clr ? '0 : o_sum_re;
            r_acc_im <= i_clr ? '0 : o_sum_im;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_ed2.sv
`default_nettype none
// ============================================================================
// Module   : memory_ed2
// Brief    : Asynchronous twiddle ROM: cos(2*pi*m/N) and -sin(2*pi*m/N) in Q1.6.
// Revision : 1.0 - initial release
// ============================================================================
module memory_ed2
    import dft_pkg::*;
#(
    parameter int N  = DFT_N,
    parameter int AW = IDX_W
) (
    input  logic [AW-1:0]          i_addr,
    output logic signed [TW_W-1:0] o_cos,
    output logic signed [TW_W-1:0] o_msin
);
    // The 64-point table serves every legal N by stepping 64/N entries per index
    localparam int c_SHIFT = 6 - $clog2(N);

    logic [5:0] w_phase;

    assign w_phase = 6'(i_addr) << c_SHIFT;
    assign o_cos   = cos64(w_phase);
    assign o_msin  = -cos64(w_phase + 6'd48);

endmodule
`default_nettype wire

// File: rtl/dft_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dft_sequencer
// Brief    : N-point DFT with one time-shared CMAC (N*N cycles per frame).
//            Define DFT_INVERSE_EN to add the per-frame inverse-select input.
// Revision : 1.0 - initial release
// ============================================================================
module dft_sequencer
    import dft_pkg::*;
#(
    parameter int N = DFT_N,
    parameter int W = DFT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    dft_sequencer_if.slave  bus
);
    localparam int c_IDX_W = $clog2(N);
    localparam int c_ACC_W = W + N;
    localparam int c_XW    = W + 1;

    localparam logic [1:0]         c_ST_LOAD    = LOAD;
    localparam logic [1:0]         c_ST_COMPUTE = COMPUTE;
    localparam logic [1:0]         c_ST_DRAIN   = DRAIN;
    localparam logic [c_IDX_W-1:0] c_LAST       = c_IDX_W'(N - 1);

    logic [1:0]                r_state;
    logic [c_IDX_W-1:0]        r_load_cnt;
    logic [c_IDX_W-1:0]        r_k;
    logic [c_IDX_W-1:0]        r_j;
    logic [c_IDX_W-1:0]        r_t;
    logic [c_IDX_W-1:0]        r_out_idx;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic signed [c_ACC_W-1:0] r_out_re;
    logic signed [c_ACC_W-1:0] r_out_im;

    logic signed [c_XW-1:0]    r_x_re [N];
    logic signed [c_XW-1:0]    r_x_im [N];
    logic signed [c_ACC_W-1:0] r_y_re [N];
    logic signed [c_ACC_W-1:0] r_y_im [N];

    logic                      w_in_fire;
    logic                      w_mac_en;
    logic                      w_mac_last;
    logic                      w_neg_s;
    logic [c_IDX_W-1:0]        w_next_idx;
    logic signed [TW_W-1:0]    w_cos;
    logic signed [TW_W-1:0]    w_msin;
    logic signed [c_ACC_W-1:0] w_sum_re;
    logic signed [c_ACC_W-1:0] w_sum_im;

    assign w_in_fire  = bus.in_valid && (r_state == c_ST_LOAD);
    assign w_mac_en   = (r_state == c_ST_COMPUTE);
    assign w_mac_last = w_mac_en && (r_j == c_LAST);
    assign w_next_idx = r_out_idx + 1'b1;

    assign bus.in_ready  = (r_state == c_ST_LOAD);
    assign bus.busy      = (r_state == c_ST_COMPUTE) || (r_state == c_ST_DRAIN);
    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

`ifdef DFT_INVERSE_EN
    logic r_inverse;

    // Direction is latched once per frame, on its first accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_inverse <= 1'b0;
        else if (w_in_fire && (r_load_cnt == '0))
            r_inverse <= bus.inverse;
    end
    assign w_neg_s = r_inverse;
`else
    assign w_neg_s = 1'b0;
`endif

    memory_ed2 #(
        .N  (N),
        .AW (c_IDX_W)
    ) u_twiddle (
        .i_addr (r_t),
        .o_cos  (w_cos),
        .o_msin (w_msin)
    );

    dft_cmac #(
        .XW (c_XW),
        .TW (TW_W),
        .AW (c_ACC_W)
    ) u_cmac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_mac_en),
        .i_clr    (w_mac_last),
        .i_neg_s  (w_neg_s),
        .i_xr     (r_x_re[r_j]),
        .i_xi     (r_x_im[r_j]),
        .i_c      (w_cos),
        .i_s      (w_msin),
        .o_sum_re (w_sum_re),
        .o_sum_im (w_sum_im)
    );

    // Sample and bin storage carry no reset; control state gates their use
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_x_re[r_load_cnt] <= bus.in_re;
            r_x_im[r_load_cnt] <= bus.in_im;
        end
        if (w_mac_last) begin
            r_y_re[r_k] <= w_sum_re;
            r_y_im[r_k] <= w_sum_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_LOAD;
            r_load_cnt  <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_t         <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_load_cnt == c_LAST) begin
                            r_load_cnt <= '0;
                            r_state    <= c_ST_COMPUTE;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    // t tracks (k*j) mod N; natural wrap of the index width does the mod
                    if (r_j == c_LAST) begin
                        r_j <= '0;
                        r_t <= '0;
                        if (r_k == c_LAST) begin
                            r_k     <= '0;
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                        r_t <= r_t + r_k;
                    end
                end
                c_ST_DRAIN: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_re    <= r_y_re[r_out_idx];
                        r_out_im    <= r_y_im[r_out_idx];
                        r_out_last  <= (r_out_idx == c_LAST);
                    end else if (bus.out_ready) begin
                        if (r_out_idx == c_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_idx   <= '0;
                            r_state     <= c_ST_LOAD;
                        end else begin
                            r_out_idx  <= w_next_idx;
                            r_out_re   <= r_y_re[w_next_idx];
                            r_out_im   <= r_y_im[w_next_idx];
                            r_out_last <= (w_next_idx == c_LAST);
                        end
                    end
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire
